// File: rtl/sim_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : sim_run_controller
// Purpose  : Run controller for a simulation top. Holds the harness in reset
//            for RESET_DELAY cycles, then counts run cycles while watching
//            N_CH success/fail/progress channels. The run ends with a sticky
//            status of pass, fail, timeout or stall. A restart pulse re-enters
//            the reset hold without re-elaborating.
// Ports    : clock, reset        - clock, synchronous active-high reset
//            max_cycles          - run-cycle budget (0 disables timeout)
//            wdog_limit          - max cycles without progress (0 disables)
//            restart             - 1-cycle pulse, back to reset hold
//            verbose_en          - verbose level enable for printf_cond
//            ch_success/fail/progress - per-channel harness monitors
//            harness_reset       - reset to the harness
//            running, done       - run phase / sticky end of run
//            status              - 0 none, 1 pass, 2 fail, 3 timeout, 4 stall
//            fail_ch             - lowest failing channel (status == 2)
//            cycle_count         - run cycles elapsed, frozen at end of run
//            printf_cond         - verbose_en && !harness_reset
// Revision : 1.0 - initial release
// ============================================================================
module sim_run_controller #(
    parameter int  N_CH        = 4,
    parameter int  RESET_DELAY = 10,
    parameter int  CNT_W       = 64,
    parameter int  WDOG_W      = 32,
    localparam int CH_IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CNT_W-1:0]    max_cycles,
    input  logic [WDOG_W-1:0]   wdog_limit,
    input  logic                restart,
    input  logic                verbose_en,
    input  logic [N_CH-1:0]     ch_success,
    input  logic [N_CH-1:0]     ch_fail,
    input  logic [N_CH-1:0]     ch_progress,
    output logic                harness_reset,
    output logic                running,
    output logic                done,
    output logic [2:0]          status,
    output logic [CH_IDX_W-1:0] fail_ch,
    output logic [CNT_W-1:0]    cycle_count,
    output logic                printf_cond
);

    // hold_cnt only spans 0..RESET_DELAY-1
    localparam int                  c_HOLD_W    = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RESET_DELAY - 1);

    localparam logic [1:0] c_S_HOLD = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    localparam logic [2:0] c_ST_NONE    = 3'd0;
    localparam logic [2:0] c_ST_PASS    = 3'd1;
    localparam logic [2:0] c_ST_FAIL    = 3'd2;
    localparam logic [2:0] c_ST_TIMEOUT = 3'd3;
    localparam logic [2:0] c_ST_STALL   = 3'd4;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_harness_reset;
    logic                r_running;
    logic                r_done;
    logic [2:0]          r_status;
    logic [CH_IDX_W-1:0] r_fail_ch;
    logic [CNT_W-1:0]    r_cycle_count;
    logic [WDOG_W-1:0]   r_wdog_cnt;
    logic [N_CH-1:0]     r_seen;

    logic                w_hold_end;
    logic                w_progress;
    logic                w_pass;
    logic                w_fail;
    logic                w_stall;
    logic                w_timeout;
    logic                w_event;
    logic [2:0]          w_event_status;
    logic [CH_IDX_W-1:0] w_fail_idx;

    // ------------------------------------------------------------------
    // Run-phase event detection
    // ------------------------------------------------------------------
    always_comb begin
        w_hold_end = (r_hold_cnt == c_HOLD_LAST);
        // success also counts as a heartbeat for the watchdog
        w_progress = (|ch_progress) || (|ch_success);
        w_pass     = &(r_seen | ch_success);
        w_fail     = |ch_fail;
        w_stall    = (wdog_limit != '0) &&
                     (r_wdog_cnt == (wdog_limit - WDOG_W'(1))) && !w_progress;
        w_timeout  = (max_cycles != '0) &&
                     (r_cycle_count == (max_cycles - CNT_W'(1)));
        w_event    = w_fail || w_pass || w_stall || w_timeout;

        // same-cycle priority: fail, pass, stall, timeout
        w_event_status = c_ST_NONE;
        if (w_fail) begin
            w_event_status = c_ST_FAIL;
        end else if (w_pass) begin
            w_event_status = c_ST_PASS;
        end else if (w_stall) begin
            w_event_status = c_ST_STALL;
        end else if (w_timeout) begin
            w_event_status = c_ST_TIMEOUT;
        end

        // scan downward so the lowest set index wins
        w_fail_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_fail[i]) begin
                w_fail_idx = CH_IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_HOLD: if (w_hold_end) w_state_nxt = c_S_RUN;
            c_S_RUN:  if (w_event)    w_state_nxt = c_S_DONE;
            c_S_DONE: w_state_nxt = c_S_DONE;
            default:  w_state_nxt = c_S_HOLD;
        endcase
        // restart overrides any event seen in the same cycle
        if (restart) begin
            w_state_nxt = c_S_HOLD;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            r_hold_cnt      <= '0;
            r_harness_reset <= 1'b1;
            r_running       <= 1'b0;
            r_done          <= 1'b0;
            r_status        <= c_ST_NONE;
            r_fail_ch       <= '0;
            r_cycle_count   <= '0;
            r_wdog_cnt      <= '0;
            r_seen          <= '0;
        end else begin
            case (r_state)
                c_S_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                    if (w_hold_end) begin
                        r_harness_reset <= 1'b0;
                        r_running       <= 1'b1;
                    end
                end
                c_S_RUN: begin
                    if (w_event) begin
                        // cycle_count is left at the index of the final run cycle
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                        r_status  <= w_event_status;
                        r_fail_ch <= w_fail ? w_fail_idx : '0;
                    end else begin
                        if (r_cycle_count != '1) begin
                            r_cycle_count <= r_cycle_count + CNT_W'(1);
                        end
                        r_wdog_cnt <= w_progress ? '0 : (r_wdog_cnt + WDOG_W'(1));
                        r_seen     <= r_seen | ch_success;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign harness_reset = r_harness_reset;
    assign running       = r_running;
    assign done          = r_done;
    assign status        = r_status;
    assign fail_ch       = r_fail_ch;
    assign cycle_count   = r_cycle_count;
    assign printf_cond   = verbose_en && !r_harness_reset;

endmodule
`default_nettype wire

// File: tb/tb_sim_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_run_controller
// Purpose  : Self-checking bench for sim_run_controller. A cycle-level
//            reference model tracks hold time remaining, run index, the set of
//            channels that have succeeded and the length of the current quiet
//            stretch, and every output is compared after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_run_controller;

    localparam int N_CH        = 4;
    localparam int RESET_DELAY = 10;
    localparam int CNT_W       = 64;
    localparam int WDOG_W      = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [CNT_W-1:0] max_cycles = '0;
    logic [WDOG_W-1:0] wdog_limit = '0;
    logic             restart = 1'b0;
    logic             verbose_en = 1'b0;
    logic [N_CH-1:0]  ch_success = '0;
    logic [N_CH-1:0]  ch_fail = '0;
    logic [N_CH-1:0]  ch_progress = '0;
    logic             harness_reset;
    logic             running;
    logic             done;
    logic [2:0]       status;
    logic [1:0]       fail_ch;
    logic [CNT_W-1:0] cycle_count;
    logic             printf_cond;

    sim_run_controller #(
        .N_CH        (N_CH),
        .RESET_DELAY (RESET_DELAY),
        .CNT_W       (CNT_W),
        .WDOG_W      (WDOG_W)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .max_cycles    (max_cycles),
        .wdog_limit    (wdog_limit),
        .restart       (restart),
        .verbose_en    (verbose_en),
        .ch_success    (ch_success),
        .ch_fail       (ch_fail),
        .ch_progress   (ch_progress),
        .harness_reset (harness_reset),
        .running       (running),
        .done          (done),
        .status        (status),
        .fail_ch       (fail_ch),
        .cycle_count   (cycle_count),
        .printf_cond   (printf_cond)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int              m_hold_left = RESET_DELAY;
    longint unsigned m_idx       = 0;   // run cycles completed
    logic [N_CH-1:0] m_seen      = '0;
    longint unsigned m_quiet     = 0;   // consecutive run cycles without progress
    bit              m_done      = 1'b0;
    int              m_status    = 0;
    int              m_fail_ch   = 0;

    int mode      = 0;
    int succ_rate = 30;
    int fail_rate = 200;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply the rules of one clock edge to the model using the current inputs.
    task automatic model_step();
        logic [N_CH-1:0] sn;
        bit prog, f, p, s, t;
        int lo;
        if (reset || restart) begin
            m_hold_left = RESET_DELAY;
            m_idx       = 0;
            m_seen      = '0;
            m_quiet     = 0;
            m_done      = 1'b0;
            m_status    = 0;
            m_fail_ch   = 0;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
        end else if (!m_done) begin
            prog = (ch_progress != '0) || (ch_success != '0);
            sn   = m_seen | ch_success;
            f    = (ch_fail != '0);
            p    = (sn == '1);
            s    = (wdog_limit != '0) && !prog && (m_quiet + 1 == longint'(wdog_limit));
            t    = (max_cycles != '0) && (m_idx + 1 == max_cycles);
            if (f || p || s || t) begin
                m_done = 1'b1;
                if (f) begin
                    m_status = 2;
                    lo = -1;
                    for (int i = 0; i < N_CH; i++) if (ch_fail[i] && lo < 0) lo = i;
                    m_fail_ch = lo;
                end else if (p) m_status = 1;
                else if (s)     m_status = 4;
                else            m_status = 3;
            end else begin
                m_seen  = sn;
                m_quiet = prog ? 0 : m_quiet + 1;
                m_idx   = m_idx + 1;
            end
        end
    endtask

    task automatic compare_all();
        bit exp_hr;
        exp_hr = (m_hold_left > 0);
        check("harness_reset", harness_reset, exp_hr);
        check("running", running, (!exp_hr && !m_done));
        check("done", done, m_done);
        check("status", status, m_status);
        check("fail_ch", fail_ch, m_fail_ch);
        check("cycle_count", cycle_count, m_idx);
        check("printf_cond", printf_cond, (verbose_en && !exp_hr));
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive_inputs();
        bit act;
        int k;
        act = (m_hold_left == 0) && !m_done;
        ch_success  = '0;
        ch_fail     = '0;
        ch_progress = '0;
        case (mode)
            3: if (act) begin
                if (m_idx == 5)  ch_success = 4'b0001;
                if (m_idx == 9)  ch_success = 4'b0010;
                if (m_idx == 20) ch_success = 4'b0100;
                if (m_idx == 40) ch_success = 4'b1000;
            end
            4: if (act && m_idx == 3) begin
                ch_fail    = 4'b0110;
                ch_success = 4'b1111;
            end
            5: if (act && (m_idx % 10 == 9) && m_idx < 100) ch_progress = 4'b0001;
            6: if (act && m_idx == 4) ch_fail = 4'b1000;
            9: begin
                // random activity is also driven during hold/done, where it must be ignored
                for (int i = 0; i < N_CH; i++) begin
                    if ($urandom_range(0, succ_rate) == 0) ch_success[i] = 1'b1;
                    if ($urandom_range(0, 7) == 0)         ch_progress[i] = 1'b1;
                end
                if ($urandom_range(0, fail_rate) == 0) begin
                    k = $urandom_range(0, N_CH - 1);
                    ch_fail[k] = 1'b1;
                end
                if ($urandom_range(0, 9) == 0) ch_fail = ch_fail | 4'($urandom_range(0, 15) & 4'($urandom_range(0, 15)));
                if ($urandom_range(0, 1) == 0) ch_fail = '0;
            end
            default: begin
            end
        endcase
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input string tag);
        int n;
        n = 0;
        while (!done && n < budget) begin
            drive_inputs();
            step();
            n++;
        end
        check(tag, done, 1);
    endtask

    initial begin
        int hl;
        int n;

        // reset state
        max_cycles = 1000;
        wdog_limit = 0;
        repeat (3) step();
        check("reset_hr", harness_reset, 1);
        check("reset_status", status, 0);
        check("reset_count", cycle_count, 0);

        // T1: harness_reset length after reset falls
        reset = 1'b0;
        hl = 0;
        while (harness_reset && hl < 30) begin
            hl++;
            step();
        end
        check("t1_hold_len", hl, RESET_DELAY);
        check("t1_running", running, 1);

        // T2: timeout with idle channels
        mode = 0;
        run_until_done(1100, "t2_done");
        check("t2_status", status, 3);
        check("t2_count", cycle_count, 999);
        repeat (3) step();
        check("t2_frozen", cycle_count, 999);

        // T3: staggered success pulses
        max_cycles = 0;
        mode = 3;
        pulse_restart();
        run_until_done(100, "t3_done");
        check("t3_status", status, 1);
        check("t3_count", cycle_count, 40);

        // T4: fail beats pass, lowest index reported
        mode = 4;
        pulse_restart();
        run_until_done(50, "t4_done");
        check("t4_status", status, 2);
        check("t4_fail_ch", fail_ch, 1);

        // T5: watchdog stall after progress stops
        wdog_limit = 50;
        mode = 5;
        pulse_restart();
        run_until_done(200, "t5_done");
        check("t5_status", status, 4);
        check("t5_count", cycle_count, 149);

        // T5b: fail and stall in the same cycle
        wdog_limit = 5;
        mode = 6;
        pulse_restart();
        run_until_done(50, "t5b_done");
        check("t5b_status", status, 2);
        check("t5b_fail_ch", fail_ch, 3);

        // T6: restart from DONE, from RUN, and with a same-cycle fail
        verbose_en = 1'b1;
        wdog_limit = 0;
        mode = 0;
        drive_inputs();
        pulse_restart();
        check("t6_done_hr", harness_reset, 1);
        check("t6_done_status", status, 0);
        check("t6_done_fail_ch", fail_ch, 0);
        check("t6_printf_hold", printf_cond, 0);
        repeat (14) step();
        check("t6_run", running, 1);
        check("t6_printf_run", printf_cond, 1);
        pulse_restart();
        check("t6_run_hr", harness_reset, 1);
        check("t6_run_count", cycle_count, 0);
        repeat (12) step();
        ch_fail = 4'b0001;
        pulse_restart();
        ch_fail = '0;
        check("t6_failrst_status", status, 0);
        check("t6_failrst_hr", harness_reset, 1);
        check("t6_failrst_done", done, 0);

        // randomized runs
        mode = 9;
        for (int r = 0; r < 40; r++) begin
            max_cycles = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(10, 150);
            wdog_limit = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 30);
            verbose_en = 1'($urandom_range(0, 1));
            succ_rate  = $urandom_range(10, 60);
            fail_rate  = $urandom_range(50, 400);
            if ($urandom_range(0, 4) == 0) begin
                reset = 1'b1;
                drive_inputs();
                step();
                step();
                reset = 1'b0;
            end else begin
                drive_inputs();
                pulse_restart();
            end
            n = 0;
            while (!m_done && n < 400) begin
                if ($urandom_range(0, 150) == 0) restart = 1'b1;
                drive_inputs();
                step();
                restart = 1'b0;
                n++;
            end
            repeat (3) begin
                drive_inputs();
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "bench did not finish in time");
    end

endmodule
`default_nettype wire
